writeback_buffer: RTL and testbench
===================================

// Module: writeback_buffer
// PURPOSE
//  Write-side initiator for the 32x32 register file. Queues writeback requests
//  from the execute/memory stages and drains them one per clock onto the file's
//  regWrite/write_reg/write_data port, in order. Gives read-port bypass so that
//  decode sees pending (uncommitted) values. Sits between the pipeline and the
//  register file.
// PARAMETERS
//  DEPTH   4   FIFO entries; power of two, >= 2
//  DATA_W  32  data width
//  ADDR_W  5   register index width
// PORTS
//  clk         in   1                    rising-edge clock
//  rst_n       in   1                    async active-low reset
//  wb_valid    in   1                    producer request valid
//  wb_ready    out  1                    buffer can accept; = !full (combinational)
//  wb_reg      in   ADDR_W               destination register
//  wb_data     in   DATA_W               value to write
//  wr_stall    in   1                    register-file write port busy; hold drain
//  flush       in   1                    discard all pending entries
//  regWrite    out  1                    write strobe to register file (registered)
//  write_reg   out  ADDR_W               write index (registered)
//  write_data  out  DATA_W               write value (registered)
//  read_reg1   in   ADDR_W               bypass lookup index, port 1
//  byp_hit1    out  1                    pending value exists for read_reg1
//  byp_data1   out  DATA_W               youngest pending value for read_reg1
//  read_reg2   in   ADDR_W               bypass lookup index, port 2
//  byp_hit2    out  1                    as port 1
//  byp_data2   out  DATA_W               as port 1
//  count       out  $clog2(DEPTH+1)      entries held in FIFO (excl. output stage)
// BEHAVIOUR
//  - Reset (async, rst_n=0): FIFO empty, pointers 0, count=0, regWrite=0,
//    write_reg=0, write_data=0; wb_ready=1 once empty.
//  - Push: wb_valid && wb_ready at edge. wb_reg==0: accepted, not stored.
//  - Drain, per edge: if !empty && !wr_stall, load head into write_reg/write_data,
//    regWrite<=1, pop. Otherwise regWrite<=0. regWrite is a one-cycle pulse per entry.
//  - Latency: entry pushed at edge N drives regWrite from edge N+1 (empty, no stall).
//  - Push and pop on the same edge: both happen; count unchanged. When full,
//    wb_ready=0 even if a pop happens that edge (no pass-through).
//  - Ordering: strict FIFO; two writes to the same register commit in push order.
//  - Bypass (combinational): search output stage (only when regWrite=1) and valid
//    FIFO entries. The youngest match wins: tail-1 first, then head, then output stage.
//    read_regN==0 gives hit=0, data=0. No match gives hit=0, data=0. Entries accepted
//    this edge are not visible until the next cycle.
//  - flush (sync): on the edge, empty the FIFO, count<=0, regWrite<=0. It overrides
//    push and drain on that edge. write_reg/write_data keep their values.
//  - count wraps never; pointers are ADDR of log2(DEPTH) bits and wrap modulo DEPTH.
//  - Reset mid-drain: pending entries are lost; regWrite drops immediately (async).
// TESTING
//  1 reset, push (r3,0xDEADBEEF) -> next edge regWrite=1, write_reg=3,
//    write_data=0xDEADBEEF for exactly 1 cycle; count back to 0.
//  2 wr_stall=1, push r1..r4 -> count=4, wb_ready=0, regWrite=0; release stall ->
//    r1,r2,r3,r4 on 4 consecutive cycles.
//  3 push (r5,0x11) then (r5,0x22) under stall, read_reg1=5 -> byp_hit1=1,
//    byp_data1=0x22; read_reg2=6 -> byp_hit2=0.
//  4 push (r0,0xFFFF) -> accepted, count stays 0, no regWrite; read_reg1=0 -> hit=0.
//  5 full FIFO, assert flush along with wb_valid -> next cycle count=0, regWrite=0,
//    pushed entry dropped.
//  6 rst_n low while regWrite=1 -> regWrite=0 without a clock; count=0 after release.

Source files
------------

// File: rtl/writeback_buffer.sv
// ============================================================================
// Module      : writeback_buffer
// Description : In-order writeback FIFO that drains one entry per clock into
//               the register-file write port, with two-port read bypass.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module writeback_buffer #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wb_valid,
  output logic                       wb_ready,
  input  logic [ADDR_W-1:0]          wb_reg,
  input  logic [DATA_W-1:0]          wb_data,
  input  logic                       wr_stall,
  input  logic                       flush,
  output logic                       regWrite,
  output logic [ADDR_W-1:0]          write_reg,
  output logic [DATA_W-1:0]          write_data,
  input  logic [ADDR_W-1:0]          read_reg1,
  output logic                       byp_hit1,
  output logic [DATA_W-1:0]          byp_data1,
  input  logic [ADDR_W-1:0]          read_reg2,
  output logic                       byp_hit2,
  output logic [DATA_W-1:0]          byp_data2,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = $clog2(DEPTH+1);

  logic [ADDR_W-1:0]  r_mem_reg  [DEPTH];
  logic [DATA_W-1:0]  r_mem_data [DEPTH];
  logic [c_PTR_W-1:0] r_head;
  logic [c_PTR_W-1:0] r_tail;
  logic [c_CNT_W-1:0] r_count;

  logic w_full;
  logic w_empty;
  logic w_accept;
  logic w_push;
  logic w_pop;

  assign w_full   = (r_count == c_CNT_W'(DEPTH));
  assign w_empty  = (r_count == '0);
  assign wb_ready = !w_full;
  assign count    = r_count;

  // Writes to r0 complete the handshake but are never stored.
  assign w_accept = wb_valid && wb_ready && !flush;
  assign w_push   = w_accept && (wb_reg != '0);
  assign w_pop    = !w_empty && !wr_stall && !flush;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_reg[r_tail]  <= wb_reg;
      r_mem_data[r_tail] <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      regWrite   <= 1'b0;
      write_reg  <= '0;
      write_data <= '0;
    end else if (flush) begin
      r_head   <= '0;
      r_tail   <= '0;
      r_count  <= '0;
      regWrite <= 1'b0;
    end else begin
      if (w_pop) begin
        regWrite   <= 1'b1;
        write_reg  <= r_mem_reg[r_head];
        write_data <= r_mem_data[r_head];
        r_head     <= r_head + 1'b1;
      end else begin
        regWrite <= 1'b0;
      end
      if (w_push) begin
        r_tail <= r_tail + 1'b1;
      end
      r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
    end
  end

  // Bypass: scan oldest to youngest so the youngest match is left standing.
  logic [ADDR_W-1:0] w_rd [2];
  assign w_rd[0] = read_reg1;
  assign w_rd[1] = read_reg2;

  for (genvar p = 0; p < 2; p++) begin : g_byp
    logic               w_hit;
    logic [DATA_W-1:0]  w_dat;
    logic [c_PTR_W-1:0] w_idx;

    always_comb begin
      w_hit = 1'b0;
      w_dat = '0;
      w_idx = '0;
      if (w_rd[p] != '0) begin
        if (regWrite && (write_reg == w_rd[p])) begin
          w_hit = 1'b1;
          w_dat = write_data;
        end
        for (int k = 0; k < DEPTH; k++) begin
          w_idx = r_head + c_PTR_W'(k);
          if ((c_CNT_W'(k) < r_count) && (r_mem_reg[w_idx] == w_rd[p])) begin
            w_hit = 1'b1;
            w_dat = r_mem_data[w_idx];
          end
        end
      end
    end
  end

  assign byp_hit1  = g_byp[0].w_hit;
  assign byp_data1 = g_byp[0].w_dat;
  assign byp_hit2  = g_byp[1].w_hit;
  assign byp_data2 = g_byp[1].w_dat;

endmodule

`default_nettype wire

// File: tb/tb_writeback_buffer.sv
// ============================================================================
// Module      : tb_writeback_buffer
// Description : Directed self-checking bench for writeback_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_writeback_buffer;

  logic        clk;
  logic        rst_n;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        wr_stall;
  logic        flush;
  logic        regWrite;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [4:0]  read_reg1;
  logic        byp_hit1;
  logic [31:0] byp_data1;
  logic [4:0]  read_reg2;
  logic        byp_hit2;
  logic [31:0] byp_data2;
  logic [2:0]  count;

  int n_cmp = 0;
  int n_err = 0;

  writeback_buffer #(.DEPTH(4), .DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_reg(wb_reg), .wb_data(wb_data), .wr_stall(wr_stall), .flush(flush),
    .regWrite(regWrite), .write_reg(write_reg), .write_data(write_data),
    .read_reg1(read_reg1), .byp_hit1(byp_hit1), .byp_data1(byp_data1),
    .read_reg2(read_reg2), .byp_hit2(byp_hit2), .byp_data2(byp_data2),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; inputs change and outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; wb_valid = 1'b0; wb_reg = '0; wb_data = '0;
    wr_stall = 1'b0; flush = 1'b0; read_reg1 = '0; read_reg2 = '0;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", count); end
    n_cmp++; if (regWrite !== 1'b0) begin n_err++; $display("FAIL reset_regwrite got %b want 0", regWrite); end
    n_cmp++; if (write_reg !== 5'd0 || write_data !== 32'd0) begin n_err++; $display("FAIL reset_wr got %0d/%h want 0/0", write_reg, write_data); end
    n_cmp++; if (wb_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", wb_ready); end
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    wb_valid = 1'b1; wb_reg = 5'd3; wb_data = 32'hDEADBEEF; read_reg1 = 5'd3;
    step();
    wb_valid = 1'b0;
    n_cmp++; if (count !== 3'd1 || regWrite !== 1'b0) begin n_err++; $display("FAIL single_queued got cnt=%0d rw=%b want 1/0", count, regWrite); end
    n_cmp++; if (byp_hit1 !== 1'b1 || byp_data1 !== 32'hDEADBEEF) begin n_err++; $display("FAIL single_bypass got %b/%h want 1/deadbeef", byp_hit1, byp_data1); end
    step();
    n_cmp++; if (regWrite !== 1'b1 || write_reg !== 5'd3 || write_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL single_commit got %b/%0d/%h want 1/3/deadbeef", regWrite, write_reg, write_data); end
    n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL single_count got %0d want 0", count); end
    step();
    n_cmp++; if (regWrite !== 1'b0) begin n_err++; $display("FAIL single_pulse got %b want 0", regWrite); end
    read_reg1 = '0;
  endtask

  task automatic test_stall();
    wr_stall = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      wb_valid = 1'b1; wb_reg = 5'(i); wb_data = 32'h100 + 32'(i);
      step();
    end
    wb_valid = 1'b0;
    n_cmp++; if (count !== 3'd4 || wb_ready !== 1'b0 || regWrite !== 1'b0) begin n_err++; $display("FAIL stall_full got cnt=%0d rdy=%b rw=%b want 4/0/0", count, wb_ready, regWrite); end
    wr_stall = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      n_cmp++; if (regWrite !== 1'b1 || write_reg !== 5'(i) || write_data !== 32'h100 + 32'(i)) begin n_err++; $display("FAIL stall_drain%0d got %b/%0d/%h want 1/%0d/%h", i, regWrite, write_reg, write_data, i, 32'h100 + 32'(i)); end
    end
    step();
    n_cmp++; if (regWrite !== 1'b0 || count !== 3'd0) begin n_err++; $display("FAIL stall_idle got rw=%b cnt=%0d want 0/0", regWrite, count); end
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 3; i++) begin
      wb_valid = 1'b1; wb_reg = 5'(10 + i); wb_data = 32'hA0 + 32'(i);
      step();
      n_cmp++; if (count !== 3'd1) begin n_err++; $display("FAIL b2b_count%0d got %0d want 1", i, count); end
      if (i > 1) begin
        n_cmp++; if (regWrite !== 1'b1 || write_reg !== 5'(9 + i)) begin n_err++; $display("FAIL b2b_commit%0d got %b/%0d want 1/%0d", i, regWrite, write_reg, 9 + i); end
      end
    end
    wb_valid = 1'b0;
    step();
    n_cmp++; if (regWrite !== 1'b1 || write_reg !== 5'd13 || write_data !== 32'hA3 || count !== 3'd0) begin n_err++; $display("FAIL b2b_last got %b/%0d/%h/%0d want 1/13/a3/0", regWrite, write_reg, write_data, count); end
    step();
  endtask

  task automatic test_bypass();
    wr_stall = 1'b1; read_reg1 = 5'd5; read_reg2 = 5'd6;
    wb_valid = 1'b1; wb_reg = 5'd5; wb_data = 32'h11;
    step();
    wb_data = 32'h22;
    n_cmp++; if (byp_hit1 !== 1'b1 || byp_data1 !== 32'h11) begin n_err++; $display("FAIL byp_first got %b/%h want 1/11", byp_hit1, byp_data1); end
    step();
    wb_valid = 1'b0;
    n_cmp++; if (byp_hit1 !== 1'b1 || byp_data1 !== 32'h22) begin n_err++; $display("FAIL byp_youngest got %b/%h want 1/22", byp_hit1, byp_data1); end
    n_cmp++; if (byp_hit2 !== 1'b0 || byp_data2 !== 32'h0) begin n_err++; $display("FAIL byp_miss got %b/%h want 0/0", byp_hit2, byp_data2); end
    wr_stall = 1'b0;
    step();
    // Older value in the output stage, newer one still queued.
    n_cmp++; if (regWrite !== 1'b1 || write_data !== 32'h11 || byp_data1 !== 32'h22) begin n_err++; $display("FAIL byp_fifo_over_out got rw=%b wd=%h byp=%h want 1/11/22", regWrite, write_data, byp_data1); end
    step();
    n_cmp++; if (byp_hit1 !== 1'b1 || byp_data1 !== 32'h22) begin n_err++; $display("FAIL byp_outstage got %b/%h want 1/22", byp_hit1, byp_data1); end
    step();
    n_cmp++; if (byp_hit1 !== 1'b0 || byp_data1 !== 32'h0) begin n_err++; $display("FAIL byp_gone got %b/%h want 0/0", byp_hit1, byp_data1); end
    read_reg1 = '0; read_reg2 = '0;
  endtask

  task automatic test_r0();
    wb_valid = 1'b1; wb_reg = 5'd0; wb_data = 32'hFFFF; read_reg1 = 5'd0;
    #1;
    n_cmp++; if (wb_ready !== 1'b1) begin n_err++; $display("FAIL r0_ready got %b want 1", wb_ready); end
    step();
    wb_valid = 1'b0;
    n_cmp++; if (count !== 3'd0 || byp_hit1 !== 1'b0 || byp_data1 !== 32'h0) begin n_err++; $display("FAIL r0_drop got cnt=%0d hit=%b data=%h want 0/0/0", count, byp_hit1, byp_data1); end
    step();
    n_cmp++; if (regWrite !== 1'b0) begin n_err++; $display("FAIL r0_nowrite got %b want 0", regWrite); end
  endtask

  task automatic test_flush();
    wr_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wb_valid = 1'b1; wb_reg = 5'(20 + i); wb_data = 32'(i);
      step();
    end
    n_cmp++; if (count !== 3'd4) begin n_err++; $display("FAIL flush_fill got %0d want 4", count); end
    wb_reg = 5'd30; wb_data = 32'h55; flush = 1'b1; wr_stall = 1'b0;
    step();
    flush = 1'b0; wb_valid = 1'b0;
    n_cmp++; if (count !== 3'd0 || regWrite !== 1'b0) begin n_err++; $display("FAIL flush_full got cnt=%0d rw=%b want 0/0", count, regWrite); end
    n_cmp++; if (write_reg !== 5'd5 || write_data !== 32'h22) begin n_err++; $display("FAIL flush_hold got %0d/%h want 5/22", write_reg, write_data); end
    step();
    n_cmp++; if (regWrite !== 1'b0 || count !== 3'd0) begin n_err++; $display("FAIL flush_after got rw=%b cnt=%0d want 0/0", regWrite, count); end
    // Flush with room available must still drop the concurrent push.
    wr_stall = 1'b1; wb_valid = 1'b1; wb_reg = 5'd7; wb_data = 32'h77;
    step();
    wb_reg = 5'd8; flush = 1'b1; read_reg1 = 5'd8;
    step();
    flush = 1'b0; wb_valid = 1'b0; wr_stall = 1'b0;
    n_cmp++; if (count !== 3'd0 || byp_hit1 !== 1'b0) begin n_err++; $display("FAIL flush_push got cnt=%0d hit=%b want 0/0", count, byp_hit1); end
    step();
    n_cmp++; if (regWrite !== 1'b0) begin n_err++; $display("FAIL flush_nodrain got %b want 0", regWrite); end
    read_reg1 = '0;
  endtask

  task automatic test_async_reset();
    wb_valid = 1'b1; wb_reg = 5'd9; wb_data = 32'hABC;
    step();
    wb_reg = 5'd10; wb_data = 32'hDEF;
    step();
    wb_valid = 1'b0;
    n_cmp++; if (regWrite !== 1'b1 || write_reg !== 5'd9 || count !== 3'd1) begin n_err++; $display("FAIL arst_pre got %b/%0d/%0d want 1/9/1", regWrite, write_reg, count); end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (regWrite !== 1'b0 || count !== 3'd0) begin n_err++; $display("FAIL arst_drop got rw=%b cnt=%0d want 0/0", regWrite, count); end
    step();
    rst_n = 1'b1;
    step();
    n_cmp++; if (count !== 3'd0 || regWrite !== 1'b0) begin n_err++; $display("FAIL arst_post got cnt=%0d rw=%b want 0/0", count, regWrite); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stall();
    test_back_to_back();
    test_bypass();
    test_r0();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
